// File: rtl/mips_pkg.sv
// Types and constants shared by the multicycle MIPS datapath blocks.
package mips_pkg;

  localparam int unsigned MULDIV_ITERS = 32;
  localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_ITERS);

  // Write-data mux selector codes for the HI/LO sources
  localparam int unsigned WD_SEL_W = 3;
  localparam logic [WD_SEL_W-1:0] WD_SEL_HI = 3'b010;
  localparam logic [WD_SEL_W-1:0] WD_SEL_LO = 3'b011;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/mult_div_hilo_if.sv
// Control-unit to multiply/divide unit bus: start requests, operands and HI/LO results.
interface mult_div_hilo_if #(
  parameter int unsigned WIDTH = 32
);
  logic             mult_start;
  logic             div_start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output mult_start, div_start, a_in, b_in,
    input  hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  mult_start, div_start, a_in, b_in,
    output hi_out, lo_out, busy, done, div_zero
  );
endinterface

// File: rtl/mult_div_hilo.sv
// Sequential signed multiply (Booth radix-2) / divide (restoring) unit owning HI and LO.
module mult_div_hilo
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_hilo_if.slave bus
);

  localparam int unsigned PW = 2 * WIDTH + 1;
  localparam int unsigned CW = MULDIV_CNT_W;
  localparam logic [CW-1:0] CNT_LAST = CW'(MULDIV_ITERS - 1);

  muldiv_state_t    r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand, r_dvs, r_rem, r_quo, r_hi, r_lo;
  logic [PW-1:0]    r_prod;
  logic             r_neg_q, r_neg_r, r_zero, r_is_div, r_busy, r_done, r_dz;

  logic             w_last;
  logic [WIDTH:0]   w_booth_hi, w_mc_ext, w_booth_sum, w_div_shift, w_div_diff;
  logic [PW-1:0]    w_prod_nxt;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_q_res, w_r_res, w_hi_d, w_lo_d;
  logic             w_busy_d, w_done_d, w_dz_d;

  assign w_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.mult_start)     w_next = MULT;
        else if (bus.div_start) w_next = (bus.b_in == '0) ? FINISH : DIV;
      end
      MULT, DIV: if (w_last) w_next = FINISH;
      FINISH:    w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Booth step: W+1-bit upper sum keeps the most-negative multiplicand from overflowing
  always_comb begin
    w_booth_hi = {r_prod[PW-1], r_prod[PW-1:WIDTH+1]};
    w_mc_ext   = {r_mcand[WIDTH-1], r_mcand};
    case (r_prod[1:0])
      2'b01:   w_booth_sum = w_booth_hi + w_mc_ext;
      2'b10:   w_booth_sum = w_booth_hi - w_mc_ext;
      default: w_booth_sum = w_booth_hi;
    endcase
    w_prod_nxt = {w_booth_sum, r_prod[WIDTH:1]};
  end

  assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_dvs};
  assign w_a_mag     = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
  assign w_b_mag     = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
  assign w_q_res     = r_neg_q ? -r_quo : r_quo;
  assign w_r_res     = r_neg_r ? -r_rem : r_rem;

  always_comb begin
    w_busy_d = (w_next != IDLE);
    w_done_d = (r_state == FINISH);
    w_dz_d   = (r_state == FINISH) && r_zero;
    w_hi_d   = r_hi;
    w_lo_d   = r_lo;
    if ((r_state == FINISH) && !r_zero) begin
      if (r_is_div) begin
        w_hi_d = w_r_res;
        w_lo_d = w_q_res;
      end else begin
        w_hi_d = r_prod[PW-1:WIDTH+1];
        w_lo_d = r_prod[WIDTH:1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      r_busy <= w_busy_d;
      r_done <= w_done_d;
      r_dz   <= w_dz_d;
      r_hi   <= w_hi_d;
      r_lo   <= w_lo_d;
    end
  end

  // Operand capture and per-iteration datapath
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_prod   <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
      r_is_div <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.mult_start) begin
            r_mcand  <= bus.a_in;
            r_prod   <= {WIDTH'(0), bus.b_in, 1'b0};
            r_is_div <= 1'b0;
            r_zero   <= 1'b0;
          end else if (bus.div_start) begin
            r_is_div <= 1'b1;
            r_zero   <= (bus.b_in == '0);
            r_quo    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_rem    <= '0;
            r_neg_q  <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            r_neg_r  <= bus.a_in[WIDTH-1];
          end
        end
        MULT: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt + 1'b1;
        end
        DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (!w_div_diff[WIDTH]) begin
            r_rem <= w_div_diff[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
          end else begin
            r_rem <= w_div_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out   = r_hi;
  assign bus.lo_out   = r_lo;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.div_zero = r_dz;

endmodule

// File: tb/tb_mult_div_hilo.sv
// Self-checking bench for mult_div_hilo against a plain-arithmetic HI/LO model.
module tb_mult_div_hilo;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [31:0] m_hi, m_lo;

  mult_div_hilo_if #(.WIDTH(32)) bus ();

  mult_div_hilo #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 64'(p);
  endfunction

  // Returns {remainder, quotient}; 64-bit arithmetic covers the MIN/-1 overflow case
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    q = longint'($signed(a)) / longint'($signed(b));
    r = longint'($signed(a)) % longint'($signed(b));
    return {r[31:0], q[31:0]};
  endfunction

  function automatic void model_op(input bit mul, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] v;
    if (mul) begin
      v = ref_mult(a, b);
      m_hi = v[63:32]; m_lo = v[31:0];
    end else if (b != 32'd0) begin
      v = ref_div(a, b);
      m_hi = v[63:32]; m_lo = v[31:0];
    end
  endfunction

  // Drives a start at a negedge and returns at the negedge where done is seen (or on timeout)
  task automatic run_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at, output int cycles, output logic busy0);
    bus.mult_start = mul; bus.div_start = dv; bus.a_in = a; bus.b_in = b;
    @(posedge clk); @(negedge clk);
    bus.mult_start = 1'b0; bus.div_start = 1'b0;
    bus.a_in = $urandom; bus.b_in = $urandom;
    busy0 = bus.busy;
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      bus.div_start = (cycles == inject_at);
      @(negedge clk);
      cycles++;
    end
    bus.div_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mult_start = 1'b0; bus.div_start = 1'b0; bus.a_in = '0; bus.b_in = '0;
    repeat (3) @(negedge clk);
    m_hi = '0; m_lo = '0;
    checks++; if (bus.hi_out !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi_out); end
    checks++; if (bus.lo_out !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo_out); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult_neg();
    int cyc; logic b0;
    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, cyc, b0);
    model_op(1'b1, 32'd7, 32'hFFFF_FFFD);
    checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL mult_busy_start: got %b expected 1", b0); end
    checks++; if (cyc !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", cyc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_done: got %b expected 0", bus.busy); end
    checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL mult_neg_hi: got %h expected %h", bus.hi_out, m_hi); end
    checks++; if (bus.lo_out !== m_lo) begin errors++; $display("FAIL mult_neg_lo: got %h expected %h", bus.lo_out, m_lo); end
    checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL mult_div_zero: got %b expected 0", bus.div_zero); end
  endtask

  task automatic test_mult_corner();
    int cyc; logic b0;
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, cyc, b0);
    model_op(1'b1, 32'h8000_0000, 32'h8000_0000);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL corner_latency: got %0d expected 33", cyc); end
    checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL corner_hi: got %h expected %h", bus.hi_out, m_hi); end
    checks++; if (bus.lo_out !== m_lo) begin errors++; $display("FAIL corner_lo: got %h expected %h", bus.lo_out, m_lo); end
  endtask

  task automatic test_div_neg();
    int cyc; logic b0;
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, cyc, b0);
    model_op(1'b0, 32'hFFFF_FFF9, 32'd2);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", cyc); end
    checks++; if (bus.lo_out !== m_lo) begin errors++; $display("FAIL div_neg_lo: got %h expected %h", bus.lo_out, m_lo); end
    checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL div_neg_hi: got %h expected %h", bus.hi_out, m_hi); end
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, cyc, b0);
    model_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++; if (bus.lo_out !== m_lo) begin errors++; $display("FAIL div_ovf_lo: got %h expected %h", bus.lo_out, m_lo); end
    checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL div_ovf_hi: got %h expected %h", bus.hi_out, m_hi); end
  endtask

  task automatic test_div_zero();
    int cyc; logic b0;
    run_op(1'b1, 1'b0, 32'h48D1_59E0, 32'h4000_0000, -1, cyc, b0);
    model_op(1'b1, 32'h48D1_59E0, 32'h4000_0000);
    checks++; if (bus.hi_out !== 32'h1234_5678) begin errors++; $display("FAIL dz_setup_hi: got %h expected 12345678", bus.hi_out); end
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1, cyc, b0);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL dz_latency: got %0d expected 1", cyc); end
    checks++; if (bus.div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b expected 1", bus.div_zero); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL dz_hi_hold: got %h expected %h", bus.hi_out, m_hi); end
    checks++; if (bus.lo_out !== m_lo) begin errors++; $display("FAIL dz_lo_hold: got %h expected %h", bus.lo_out, m_lo); end
    @(negedge clk);
    checks++; if ({bus.done, bus.div_zero} !== 2'b00) begin errors++; $display("FAIL dz_pulse_width: got %b expected 00", {bus.done, bus.div_zero}); end
  endtask

  task automatic test_back_to_back();
    int cyc; logic b0; logic [31:0] a, b;
    run_op(1'b1, 1'b1, 32'd6, 32'd3, 5, cyc, b0);
    model_op(1'b1, 32'd6, 32'd3);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL arb_latency: got %0d expected 33", cyc); end
    checks++; if (bus.lo_out !== m_lo) begin errors++; $display("FAIL arb_lo: got %h expected %h", bus.lo_out, m_lo); end
    checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL arb_hi: got %h expected %h", bus.hi_out, m_hi); end
    a = $urandom; b = $urandom;
    run_op(1'b1, 1'b0, a, b, -1, cyc, b0);
    model_op(1'b1, a, b);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", cyc); end
    checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL b2b_hi: got %h expected %h", bus.hi_out, m_hi); end
    checks++; if (bus.lo_out !== m_lo) begin errors++; $display("FAIL b2b_lo: got %h expected %h", bus.lo_out, m_lo); end
  endtask

  task automatic test_random();
    int cyc; int op; int exp_cyc; logic b0; logic [31:0] a, b;
    for (int i = 0; i < 20; i++) begin
      op = $urandom_range(0, 3);
      a = (op == 3) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom;
      b = $urandom;
      if (op == 2) b = 32'd0;
      else if (op == 3) b = 32'($urandom_range(1, 9));
      run_op(op == 0, op != 0, a, b, -1, cyc, b0);
      model_op(op == 0, a, b);
      exp_cyc = (op == 2) ? 1 : 33;
      checks++; if (cyc !== exp_cyc) begin errors++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, cyc, exp_cyc); end
      checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL rnd%0d_hi: a=%h b=%h got %h expected %h", i, a, b, bus.hi_out, m_hi); end
      checks++; if (bus.lo_out !== m_lo) begin errors++; $display("FAIL rnd%0d_lo: a=%h b=%h got %h expected %h", i, a, b, bus.lo_out, m_lo); end
      checks++; if (bus.div_zero !== (op == 2)) begin errors++; $display("FAIL rnd%0d_div_zero: got %b expected %b", i, bus.div_zero, op == 2); end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.mult_start = 1'b1; bus.a_in = $urandom | 32'd1; bus.b_in = $urandom | 32'd1;
    @(posedge clk); @(negedge clk);
    bus.mult_start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    m_hi = '0; m_lo = '0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL midrst_hi: got %h expected %h", bus.hi_out, m_hi); end
    checks++; if (bus.lo_out !== m_lo) begin errors++; $display("FAIL midrst_lo: got %h expected %h", bus.lo_out, m_lo); end
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses expected 0", seen); end
    checks++; if (bus.hi_out !== m_hi) begin errors++; $display("FAIL midrst_hi_hold: got %h expected %h", bus.hi_out, m_hi); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    test_reset();
    test_mult_neg();
    test_mult_corner();
    test_div_neg();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_hilo.md
# mult_div_hilo

- Sequential signed multiply/divide unit of the multicycle MIPS datapath.
- Owns the HI and LO architectural registers; `hi_out`/`lo_out` feed the HI/LO inputs of the register-file write-data multiplexer.
- Started by the control unit for MULT/DIV and reports completion with a one-cycle `done` pulse.
- Uses iterative radix-2 algorithms: a fixed 32 iteration cycles plus load and finish cycles.

## Interface
Parameters:
- `WIDTH`, 32: operand width. HI and LO are each WIDTH bits. Only 32 is verified.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `mult_start`  in  1  request signed multiply, sampled only in IDLE.
- `div_start`  in  1  request signed divide, sampled only in IDLE.
- `a_in`  in  WIDTH  multiplicand / dividend (rs).
- `b_in`  in  WIDTH  multiplier / divisor (rt).
- `hi_out`  out  WIDTH  HI register; reset 0.
- `lo_out`  out  WIDTH  LO register; reset 0.
- `busy`  out  1  operation in progress; reset 0.
- `done`  out  1  one-cycle completion pulse; reset 0.
- `div_zero`  out  1  one-cycle pulse, coincident with `done`, for a divisor of zero; reset 0.

## Operation
States: IDLE, MULT, DIV, FINISH.

- **IDLE**
  - `mult_start` = 1: latch `a_in`/`b_in`, clear iteration counter, go to MULT.
  - `mult_start` = 0, `div_start` = 1, `b_in` ≠ 0: latch operand magnitudes and both sign bits, go to DIV.
  - `div_start` = 1 with `b_in` = 0: set the zero flag and go straight to FINISH.
  - If both starts are high, MULT wins.
- **MULT**: Booth radix-2 over a 2·WIDTH+1-bit product register. Exactly 32 iterations, counter 0..31, then go to FINISH.
- **DIV**: restoring division on unsigned magnitudes, one quotient bit per cycle. 32 iterations, then go to FINISH.
- **FINISH**: write HI/LO, pulse `done`, return to IDLE.
  - MULT: HI = product[63:32], LO = product[31:0].
  - DIV: LO = quotient, negated if the operand signs differ (truncate toward zero). HI = remainder, negated if the dividend was negative.
  - Zero divisor: HI/LO unchanged, `div_zero` pulses with `done`.
- **Overflow**: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. This falls out of the magnitude algorithm and needs no special case.
- **Start pulses**: `mult_start`/`div_start` outside IDLE are ignored, with no queuing.
- **Operand stability**: `a_in`/`b_in` may change after the start edge; the latched copies are used.
- **HI/LO hold**: HI and LO change only in FINISH. They hold indefinitely otherwise.
- **Reset**: `reset` = 0 at any edge, including mid-operation, forces IDLE, clears every output and internal register to 0, and suppresses `done`. The aborted operation never completes.

## Timing
- Edge E0 samples the start, in IDLE.
- Iterations occur on E1..E32. FINISH is the state after E32; HI/LO update and `done` = 1 in the cycle after E33.
- Normal latency: `done` and the new `hi_out`/`lo_out` are visible together, 33 cycles after E0.
- `busy` = 1 from after E0 through the FINISH cycle. It is 0 while `done` = 1.
- Zero divisor: FINISH follows E0. `done` and `div_zero` are visible after E1, and `busy` is high for one cycle only.
- Back-to-back: a start sampled in the `done` cycle (state IDLE) is accepted. There are no dead cycles.
- Outputs are registered; no combinational paths from inputs to outputs.

## Structure
- Shared package `mips_pkg`:
  - state enum `muldiv_state_t` (IDLE, MULT, DIV, FINISH);
  - constant `MULDIV_ITERS` = 32;
  - widths shared with the write-data mux selector encodings (HI = 3'b010, LO = 3'b011).
- Single module; no sub-module. The Booth step and restoring-subtract step are inline combinational logic selected by state.

## Test plan
1. **Signed multiply with a negative operand.** MULT a = 7, b = 0xFFFFFFFD (−3).
   - HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
   - `done` arrives exactly 33 cycles after the start edge, and `busy` is 0 in the `done` cycle.
2. **Multiply corner case.** MULT a = b = 0x80000000.
   - HI = 0x40000000, LO = 0x00000000.
3. **Signed divide with a negative dividend.** DIV a = 0xFFFFFFF9 (−7), b = 2.
   - LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1).
   - Then DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
4. **Divide by zero.** After a MULT leaves HI = 0x12345678, issue DIV a = 5, b = 0.
   - `done` and `div_zero` pulse one cycle after the start edge.
   - HI/LO are unchanged.
5. **Start arbitration.** Assert both starts together with a = 6, b = 3: result is MULT (LO = 18).
   - A `div_start` pulsed at iteration 5 is ignored.
   - A new `mult_start` in the `done` cycle is accepted.
6. **Reset mid-operation.** Drive `reset` low at iteration 10.
   - Next cycle: `busy` = 0, HI = LO = 0.
   - No `done` ever appears for the aborted operation.
